// File: rtl/aes_iter_cipher.sv
// Iterative AES-128 encryption core: ROUNDS_PER_CYCLE rounds per clock with on-the-fly
// key expansion, valid/ready on both the plaintext/key input and the ciphertext output.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by square-and-multiply; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_round (
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic [7:0]   rcon_i,
  input  logic         last_i,
  output logic [127:0] state_o,
  output logic [127:0] rkey_o,
  output logic [7:0]   rcon_o
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] sub_s;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [127:0] shift_s;
  logic [127:0] mix_s;
  logic [31:0]  w0, w1, w2, w3;
  logic [7:0]   a0, a1, a2, a3;

  for (genvar b = 0; b < 16; b++) begin : g_sb_state
    aes_sbox u_sbox (.in_byte(state_i[127-8*b -: 8]), .out_byte(sub_s[127-8*b -: 8]));
  end

  // RotWord of the last key word before SubWord.
  assign rot_w = {rkey_i[23:0], rkey_i[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sb_key
    aes_sbox u_sbox (.in_byte(rot_w[31-8*b -: 8]), .out_byte(sub_w[31-8*b -: 8]));
  end

  always_comb begin
    w0 = rkey_i[127:96] ^ sub_w ^ {rcon_i, 24'h000000};
    w1 = rkey_i[95:64] ^ w0;
    w2 = rkey_i[63:32] ^ w1;
    w3 = rkey_i[31:0] ^ w2;
    rkey_o = {w0, w1, w2, w3};
    rcon_o = xtime(rcon_i);

    shift_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[127-8*(r+4*c) -: 8] = sub_s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end

    mix_s = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = shift_s[127-32*c -: 8];
      a1 = shift_s[119-32*c -: 8];
      a2 = shift_s[111-32*c -: 8];
      a3 = shift_s[103-32*c -: 8];
      mix_s[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mix_s[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mix_s[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mix_s[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    state_o = (last_i ? shift_s : mix_s) ^ rkey_o;
  end
endmodule

module aes_iter_cipher #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_rounds
    $error("aes_iter_cipher: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] dataout_q, dataout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         out_valid_q, out_valid_d;
  logic         load;

  // Round stages chained combinationally; stage j computes round rnd+j+1.
  for (genvar j = 0; j < R; j++) begin : g_stage
    logic [127:0] st_in, key_in, st_out, key_out;
    logic [7:0]   rc_in, rc_out;
    logic         last;

    if (j == 0) begin : g_first
      assign st_in  = state_q;
      assign key_in = rkey_q;
      assign rc_in  = rcon_q;
    end else begin : g_next
      assign st_in  = g_stage[j-1].st_out;
      assign key_in = g_stage[j-1].key_out;
      assign rc_in  = g_stage[j-1].rc_out;
    end

    assign last = (rnd_q + 4'(j + 1)) == 4'd10;

    aes_round u_round (
      .state_i (st_in),
      .rkey_i  (key_in),
      .rcon_i  (rc_in),
      .last_i  (last),
      .state_o (st_out),
      .rkey_o  (key_out),
      .rcon_o  (rc_out)
    );
  end

  assign in_ready  = ~rst & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
  assign busy      = (fsm_q == RUN);
  assign out_valid = out_valid_q;
  assign dataout   = dataout_q;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rkey_d      = rkey_q;
    rnd_d       = rnd_q;
    rcon_d      = rcon_q;
    dataout_d   = dataout_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (in_valid) load = 1'b1;
      end
      RUN: begin
        state_d = g_stage[R-1].st_out;
        rkey_d  = g_stage[R-1].key_out;
        rcon_d  = g_stage[R-1].rc_out;
        rnd_d   = rnd_q + 4'(R);
        if ((rnd_q + 4'(R)) == 4'd10) begin
          dataout_d   = g_stage[R-1].st_out;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        // Result consumed; a waiting block is taken on the same edge.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) load = 1'b1;
          else          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (load) begin
      state_d = datain ^ key;
      rkey_d  = key;
      rnd_d   = '0;
      rcon_d  = 8'h01;
      fsm_d   = RUN;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    rkey_q  <= rkey_d;
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      rcon_q      <= 8'h01;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      rcon_q      <= rcon_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: one instance per legal ROUNDS_PER_CYCLE, known-answer vectors,
// timing/backpressure/reset checks and a randomized scoreboard against a software AES-128.

module tb_aes_iter_cipher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit done_v [4];

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0] sbox_t [256];

  // S-box table built by walking the field with generator 3 and its inverse in lockstep.
  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rd < 10)
            s[4*c+r] = xt(t[4*c+r]) ^ xt(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4]
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic void chk(input int r, input string nm, input logic [127:0] act,
                              input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL R=%0d %s: got %h expected %h", r, nm, act, req);
    end
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int R  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    localparam int N  = 10 / R;
    localparam int RD = (N > 4) ? 4 : N - 1;

    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] datain, key, dataout;
    logic [127:0] exp_q [$];
    int           acc = 0;

    aes_iter_cipher #(.ROUNDS_PER_CYCLE(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .datain    (datain),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dataout   (dataout),
      .busy      (busy)
    );

    // Scoreboard: pop on every consumed output, push the model result on every accept.
    always @(negedge clk) begin
      if (!rst) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL R=%0d scoreboard: got %h expected no output", R, dataout);
          end else begin
            chk(R, "scoreboard", dataout, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(aes_ref(datain, key));
          acc++;
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                             input logic [127:0] kat, input string nm);
      int cyc, bc;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      datain    = d;
      key       = k;
      step();
      in_valid = 1'b0;
      cyc = 0;
      bc  = 0;
      while (!out_valid && cyc < 40) begin
        bc += int'(busy);
        step();
        cyc++;
      end
      chk(R, {nm, "_latency"}, 128'(cyc), 128'(N));
      chk(R, {nm, "_busy_cycles"}, 128'(bc), 128'(N));
      chk(R, {nm, "_kat"}, dataout, kat);
      step();
      chk(R, {nm, "_out_valid_clear"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
      int cyc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      datain    = '0;
      key       = '0;
      repeat (3) step();
      chk(R, "reset_in_ready", 128'(in_ready), 128'(0));
      chk(R, "reset_out_valid", 128'(out_valid), 128'(0));
      chk(R, "reset_dataout", dataout, 128'(0));
      chk(R, "reset_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      #1;
      chk(R, "idle_in_ready", 128'(in_ready), 128'(1));

      run_block(PT_B, KEY_B, CT_B, "appB");
      run_block(PT_C, KEY_C, CT_C, "appC1");

      // Backpressure with toggling inputs while the result waits.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      datain    = PT_B;
      key       = KEY_B;
      step();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
        step();
        cyc++;
      end
      chk(R, "bp_latency", 128'(cyc), 128'(N));
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'($urandom_range(1));
        datain   = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk(R, "bp_dataout_hold", dataout, CT_B);
        chk(R, "bp_out_valid_hold", 128'(out_valid), 128'(1));
        chk(R, "bp_in_ready_low", 128'(in_ready), 128'(0));
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk(R, "bp_release_in_ready", 128'(in_ready), 128'(1));
      step();
      chk(R, "bp_consumed", 128'(out_valid), 128'(0));

      // Back-to-back with in_valid and out_ready held high.
      in_valid = 1'b1;
      datain   = PT_B;
      key      = KEY_B;
      step();
      datain = PT_C;
      key    = KEY_C;
      cyc = 0;
      while (!in_ready && cyc < 40) begin
        step();
        cyc++;
      end
      chk(R, "b2b_first_result", dataout, CT_B);
      step();
      cyc++;
      in_valid = 1'b0;
      chk(R, "b2b_accept_gap", 128'(cyc), 128'(N + 1));
      cyc = 0;
      while (!out_valid && cyc < 40) begin
        step();
        cyc++;
      end
      chk(R, "b2b_second_latency", 128'(cyc), 128'(N));
      chk(R, "b2b_second_result", dataout, CT_C);
      step();

      // Reset while the block is still running.
      in_valid = 1'b1;
      datain   = PT_C;
      key      = KEY_C;
      step();
      in_valid = 1'b0;
      repeat (RD) step();
      chk(R, "rmid_busy_before", 128'(busy), 128'(1));
      rst = 1'b1;
      exp_q.delete();
      step();
      chk(R, "rmid_out_valid", 128'(out_valid), 128'(0));
      chk(R, "rmid_dataout", dataout, 128'(0));
      chk(R, "rmid_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      repeat (2) step();
      chk(R, "rmid_no_output", 128'(out_valid), 128'(0));
      run_block(PT_C, KEY_C, CT_C, "post_reset");

      // Randomized traffic on both handshakes.
      acc = 0;
      for (int c = 0; c < 60000 && acc < 1000; c++) begin
        in_valid  = ($urandom % 4) != 0;
        out_ready = ($urandom % 4) != 0;
        datain    = {$urandom, $urandom, $urandom, $urandom};
        key       = {$urandom, $urandom, $urandom, $urandom};
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk(R, "random_blocks_accepted", 128'(acc >= 1000), 128'(1));
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 40) begin
        step();
        cyc++;
      end
      chk(R, "random_drain", 128'(exp_q.size()), 128'(0));
      repeat (3) step();
      chk(R, "random_idle_out_valid", 128'(out_valid), 128'(0));
      done_v[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 90000; c++) begin
      @(posedge clk);
      if (done_v[0] && done_v[1] && done_v[2] && done_v[3]) break;
    end
    if (!(done_v[0] && done_v[1] && done_v[2] && done_v[3])) begin
      total++;
      bad++;
      $display("FAIL global_timeout: done flags %b%b%b%b expected 1111",
               done_v[3], done_v[2], done_v[1], done_v[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
